spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Converts a spike train back into a numeric value. It is the reverse of the LIF neuron, which turns an input current into spikes. Spikes are counted over a programmable window of clock cycles, and the rate is published once per window. The interval between consecutive spikes is also measured. It sits downstream of a neuron spike output so that firing rate can be driven onto the 8-bit output bus.

Parameters:
CNT_W, 8, width of the rate and ISI outputs and their saturating counters
WIN_LOG2_MIN, 4, window length exponent when window_sel=0; window = 2^(window_sel+WIN_LOG2_MIN) cycles
WIN_W, 12, width of the window down-counter; must hold 2^(7+WIN_LOG2_MIN)-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  decoder enable; low forces IDLE
clear  in  1  synchronous clear of outputs and counters
spike_in  in  1  spike from neuron; rising edge = one event
window_sel  in  3  window length select, sampled at window start
rate  out  CNT_W  spike count of last completed window, saturating
rate_valid  out  1  one-cycle pulse when rate updates
overflow  out  1  last completed window saturated rate
isi  out  CNT_W  cycles between last two events, saturating
isi_valid  out  1  one-cycle pulse when isi updates

Behaviour:
- Reset (rst_n low, async): all outputs 0; state IDLE; spike_d=0; all counters 0; has_prev=0.
- Event detection: event = spike_in & ~spike_d. spike_d registers spike_in every cycle, in all states. A held-high spike counts once.
- FSM states: IDLE, COUNT.
- IDLE:
  - Transition: if ena=1 and clear=0, go to COUNT.
  - On that transition: latch window_sel; load win_cnt = 2^(window_sel+WIN_LOG2_MIN)-1; spike_cnt=0; ovf_pend=0.
  - Events in the IDLE cycle are ignored.
- COUNT, each cycle:
  - On event: spike_cnt increments, saturating at 2^CNT_W-1. An increment attempted at saturation sets ovf_pend.
  - If win_cnt != 0: win_cnt decrements.
  - If win_cnt == 0, the window closes:
    - rate <= spike_cnt + event, saturated.
    - overflow <= ovf_pend OR the saturated add.
    - rate_valid=1 for exactly one cycle.
    - window_sel is re-sampled, win_cnt is reloaded, and spike_cnt/ovf_pend are set to 0.
    - The next window starts the following cycle with no gap.
  - An event on the closing cycle belongs to the closing window.
  - Window length is exactly 2^(window_sel+WIN_LOG2_MIN) COUNT cycles.
- ena falls in COUNT:
  - The next state is IDLE and the partial window is discarded.
  - No rate_valid; rate and overflow hold.
  - has_prev is cleared.
- clear=1 in any state:
  - Next state is IDLE.
  - rate, isi, overflow, spike_cnt, isi_tmr and has_prev go to 0; valids go to 0.
  - clear has priority over window close and events in the same cycle.
- ISI, active in COUNT only:
  - On event: if has_prev, isi <= isi_tmr and isi_valid pulses for one cycle. Then isi_tmr <= 1 and has_prev <= 1.
  - Otherwise: isi_tmr increments, saturating at 2^CNT_W-1.
  - Events at cycles t and t+k give isi=k; k > 255 gives 255.
  - The first event after entering COUNT only arms and produces no isi_valid.
  - ISI is independent of window boundaries.
- window_sel changes mid-window take effect only at the next window start.
- Outputs are all registered. rate_valid and isi_valid may assert in the same cycle.

Test Plan:
- Window and zero count: reset, then ena=1, window_sel=0, spike_in=0. Required:
  - rate_valid pulses every 16 cycles, with the first pulse 16 cycles after the first COUNT cycle.
  - rate=0 and overflow=0.
- Periodic spikes: window_sel=0, 1-cycle spikes every 4 cycles aligned to window start. Required:
  - rate=4 each window.
  - isi=4 with isi_valid on every spike after the first.
  - Holding spike_in high for 10 cycles counts as 1 event.
- Boundary event: a spike on the final cycle of a window counts in that window (rate=1). A spike on the next cycle counts in the following window (rate=1, not 2).
- Saturation: window_sel=7 (2048 cycles), spike_in toggled every cycle (1024 events). Required:
  - rate=255 and overflow=1.
  - The next window with 3 spikes gives rate=3 and overflow=0.
  - Spikes 300 cycles apart give isi=255.
- Abort and clear:
  - ena dropped mid-window after 5 spikes: no rate_valid and rate holds its prior value. Re-enabling gives a fresh full window, and the first spike gives no isi_valid.
  - clear asserted on the window-close cycle: rate_valid=0, and rate=0, isi=0.
- Async reset mid-COUNT: rst_n low between clock edges drops all outputs to 0 immediately. After release with ena=1, the first rate_valid is a full window later.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train to rate/ISI decoder: counts rising edges of spike_in over a
// power-of-two window and measures the cycle spacing between consecutive events.
module spike_rate_decoder #(
  parameter int CNT_W        = 8,
  parameter int WIN_LOG2_MIN = 4,
  parameter int WIN_W        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic             spike_in,
  input  logic [2:0]       window_sel,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state, state_nxt;
  logic             spike_d;
  logic             event_hit;
  logic             has_prev;
  logic             ovf_pend;
  logic             win_done;
  logic             cnt_sat;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spike_cnt;
  logic [CNT_W-1:0] spike_inc;
  logic [CNT_W-1:0] isi_tmr;

  // Down-counter load value: the window closes on the cycle win_cnt reads zero.
  function automatic logic [WIN_W-1:0] win_load(input logic [2:0] sel);
    logic [WIN_W:0] len;
    len = (WIN_W+1)'(1) << (int'(sel) + WIN_LOG2_MIN);
    return WIN_W'(len - (WIN_W+1)'(1));
  endfunction

  assign event_hit = spike_in & ~spike_d;
  assign win_done  = (win_cnt == '0);
  assign cnt_sat   = (spike_cnt == CNT_MAX);
  assign spike_inc = cnt_sat ? spike_cnt : spike_cnt + CNT_ONE;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ena && !clear) state_nxt = COUNT;
      COUNT: if (clear || !ena) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      spike_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      spike_d <= spike_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate       <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
      win_cnt    <= '0;
      spike_cnt  <= '0;
      ovf_pend   <= 1'b0;
      isi_tmr    <= '0;
      has_prev   <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      if (clear) begin
        rate      <= '0;
        isi       <= '0;
        overflow  <= 1'b0;
        spike_cnt <= '0;
        ovf_pend  <= 1'b0;
        isi_tmr   <= '0;
        has_prev  <= 1'b0;
      end else if (state == IDLE) begin
        if (ena) begin
          win_cnt   <= win_load(window_sel);
          spike_cnt <= '0;
          ovf_pend  <= 1'b0;
        end
      end else if (!ena) begin
        // Aborted window is dropped; rate/overflow keep the last published value.
        has_prev <= 1'b0;
      end else begin
        if (win_done) begin
          rate       <= event_hit ? spike_inc : spike_cnt;
          overflow   <= ovf_pend | (event_hit & cnt_sat);
          rate_valid <= 1'b1;
          win_cnt    <= win_load(window_sel);
          spike_cnt  <= '0;
          ovf_pend   <= 1'b0;
        end else begin
          win_cnt <= win_cnt - WIN_ONE;
          if (event_hit) begin
            spike_cnt <= spike_inc;
            if (cnt_sat) ovf_pend <= 1'b1;
          end
        end
        if (event_hit) begin
          if (has_prev) begin
            isi       <= isi_tmr;
            isi_valid <= 1'b1;
          end
          isi_tmr  <= CNT_ONE;
          has_prev <= 1'b1;
        end else if (isi_tmr != CNT_MAX) begin
          isi_tmr <= isi_tmr + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: timestamp-based reference model checked every
// cycle, a rate scoreboard, and directed scenarios with hand-computed values.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       clear = 1'b0;
  logic       spike_in = 1'b0;
  logic [2:0] window_sel = 3'd0;
  logic [7:0] rate;
  logic [7:0] isi;
  logic       rate_valid;
  logic       overflow;
  logic       isi_valid;

  int tests = 0;
  int fails = 0;

  spike_rate_decoder #(.CNT_W(8), .WIN_LOG2_MIN(4), .WIN_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .clear      (clear),
    .spike_in   (spike_in),
    .window_sel (window_sel),
    .rate       (rate),
    .rate_valid (rate_valid),
    .overflow   (overflow),
    .isi        (isi),
    .isi_valid  (isi_valid)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time 1000000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: windows as unbounded event counts, ISI as timestamp deltas.
  bit        m_active = 0;
  bit        m_prev = 0;
  bit        m_ev = 0;
  int        m_len = 0;
  int        m_pos = 0;
  int        m_count = 0;
  longint    m_cyc = 0;
  longint    m_last = -1;
  int        e_rate = 0;
  int        e_isi = 0;
  bit        e_ovf = 0;
  bit        e_rv = 0;
  bit        e_iv = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_prev = 0; m_last = -1; m_count = 0; m_pos = 0; m_len = 0;
      e_rate = 0; e_isi = 0; e_ovf = 0; e_rv = 0; e_iv = 0;
      exp_q.delete();
    end else begin
      m_ev = spike_in && !m_prev;
      m_prev = spike_in;
      m_cyc++;
      e_rv = 0;
      e_iv = 0;
      if (clear) begin
        m_active = 0; m_last = -1; e_rate = 0; e_isi = 0; e_ovf = 0;
      end else if (!m_active) begin
        if (ena) begin
          m_active = 1; m_len = 16 << window_sel; m_pos = 0; m_count = 0;
        end
      end else if (!ena) begin
        m_active = 0; m_last = -1;
      end else begin
        m_pos++;
        if (m_ev) m_count++;
        if (m_pos == m_len) begin
          e_rate = (m_count > 255) ? 255 : m_count;
          e_ovf  = (m_count > 255);
          e_rv   = 1;
          exp_q.push_back(8'(e_rate));
          m_len = 16 << window_sel; m_pos = 0; m_count = 0;
        end
        if (m_ev) begin
          if (m_last >= 0) begin
            e_isi = (m_cyc - m_last > 255) ? 255 : int'(m_cyc - m_last);
            e_iv  = 1;
          end
          m_last = m_cyc;
        end
      end
    end
  end

  // scoreboard: every cycle against the model, every rate pulse against exp_q
  always @(negedge clk) begin
    check("cyc_rate", rate, e_rate);
    check("cyc_rate_valid", rate_valid, e_rv);
    check("cyc_overflow", overflow, e_ovf);
    check("cyc_isi", isi, e_isi);
    check("cyc_isi_valid", isi_valid, e_iv);
    if (rate_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rate_sb: rate pulse with rate %0d, expected no pulse", rate);
      end else begin
        check("rate_sb", rate, exp_q.pop_front());
      end
    end
  end

  // driver / directed scenarios
  initial begin
    int pulses;
    tick(3);
    check("reset_rate", rate, 0);
    check("reset_isi", isi, 0);
    check("reset_ovf", overflow, 0);
    check("reset_rv", rate_valid, 0);
    check("reset_iv", isi_valid, 0);

    // zero-count windows of 16 cycles
    rst_n = 1; ena = 1; window_sel = 3'd0;
    tick(16);
    check("win0_early", rate_valid, 0);
    tick(1);
    check("win0_pulse1", rate_valid, 1);
    check("win0_rate", rate, 0);
    check("win0_ovf", overflow, 0);
    tick(16);
    check("win0_pulse2", rate_valid, 1);

    // spikes every 4 cycles aligned to window start
    for (int i = 0; i < 48; i++) begin
      spike_in = (i % 4 == 0);
      tick(1);
    end
    check("periodic_rv", rate_valid, 1);
    check("periodic_rate", rate, 4);
    check("periodic_isi", isi, 4);
    spike_in = 1; tick(10);
    spike_in = 0; tick(6);
    check("held_rv", rate_valid, 1);
    check("held_rate", rate, 1);
    check("held_isi", isi, 4);

    // boundary: last cycle of one window, first cycle of a later one
    tick(15);
    spike_in = 1; tick(1);
    check("bnd_last_rv", rate_valid, 1);
    check("bnd_last_rate", rate, 1);
    spike_in = 0; tick(16);
    check("bnd_empty_rate", rate, 0);
    spike_in = 1; tick(1);
    spike_in = 0; tick(15);
    check("bnd_first_rv", rate_valid, 1);
    check("bnd_first_rate", rate, 1);

    // saturation over a 2048-cycle window
    window_sel = 3'd7;
    tick(16);
    check("sat_pre_rv", rate_valid, 1);
    for (int i = 0; i < 2048; i++) begin
      spike_in = (i % 2 == 0);
      tick(1);
    end
    check("sat_rv", rate_valid, 1);
    check("sat_rate", rate, 255);
    check("sat_ovf", overflow, 1);
    for (int i = 0; i < 2048; i++) begin
      spike_in = (i == 0 || i == 300 || i == 600);
      if (i == 1000) window_sel = 3'd0;
      tick(1);
      if (i == 0) check("isi_short", isi, 2);
      if (i == 300) begin
        check("isi_sat_iv", isi_valid, 1);
        check("isi_sat", isi, 255);
      end
    end
    check("post_sat_rv", rate_valid, 1);
    check("post_sat_rate", rate, 3);
    check("post_sat_ovf", overflow, 0);

    // abort mid-window after 5 spikes
    for (int i = 0; i < 10; i++) begin
      spike_in = (i % 2 == 0);
      tick(1);
    end
    ena = 0; spike_in = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      pulses += int'(rate_valid);
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_rate_hold", rate, 3);
    ena = 1; tick(1);
    pulses = 0;
    for (int j = 0; j < 16; j++) begin
      spike_in = (j == 3 || j == 8);
      tick(1);
      if (j < 15) pulses += int'(rate_valid);
      if (j == 3) check("rearm_first_iv", isi_valid, 0);
      if (j == 8) begin
        check("rearm_second_iv", isi_valid, 1);
        check("rearm_isi", isi, 5);
      end
    end
    check("rearm_no_early", pulses, 0);
    check("rearm_rv", rate_valid, 1);
    check("rearm_rate", rate, 2);

    // clear on the closing cycle, together with a spike
    spike_in = 0; tick(15);
    clear = 1; spike_in = 1; tick(1);
    check("clear_rv", rate_valid, 0);
    check("clear_rate", rate, 0);
    check("clear_isi", isi, 0);
    check("clear_ovf", overflow, 0);
    clear = 0; spike_in = 0;

    // async reset in the middle of a window
    tick(1);
    for (int j = 0; j < 16; j++) begin
      spike_in = (j == 2 || j == 5);
      tick(1);
    end
    spike_in = 0;
    check("pre_rst_rate", rate, 2);
    check("pre_rst_isi", isi, 3);
    tick(5);
    #2 rst_n = 0;
    #1;
    check("arst_rate", rate, 0);
    check("arst_isi", isi, 0);
    check("arst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1;
    tick(16);
    check("arst_no_early", rate_valid, 0);
    tick(1);
    check("arst_rv", rate_valid, 1);
    check("arst_rate_after", rate, 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
